bcd_ex3_seq_ctrl: RTL and testbench
===================================

Name: bcd_ex3_seq_ctrl

Overview:
- Sequencer that converts a packed multi-digit BCD word to Excess-3 by time-sharing one external 4-bit BCD-to-Excess-3 converter, one digit per clock.
- Sits between a valid/ready producer and consumer. It drives the converter's 4-bit input and samples its 4-bit output.
- Also flags invalid BCD digits (value greater than 9).

Parameters:
- DIGITS, 4, number of BCD digits per word; legal range 1..8.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer has a word on in_bcd.
- in_ready  output  1  block can accept a word.
- in_bcd  input  4*DIGITS  packed BCD; digit 0 = bits [3:0].
- conv_bcd  output  4  digit driven to the shared converter's input.
- conv_ex3  input  4  converter's combinational result for conv_bcd.
- out_valid  output  1  out_ex3/out_err hold a finished result.
- out_ready  input  1  consumer accepts the result.
- out_ex3  output  4*DIGITS  packed Excess-3 result; digit 0 = bits [3:0].
- out_err  output  1  at least one input digit was greater than 9.
- busy  output  1  high in CONV or DONE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, out_ex3=0, out_err=0, conv_bcd=0, busy=0, digit index=0.
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready at a rising edge: latch in_bcd into an input register, clear the result register and the error flag, set index=0, go to CONV.
- CONV:
  - in_ready=0.
  - conv_bcd = latched digit[index], combinational from registers. Converter latency is zero (same cycle).
  - Each edge, store conv_ex3 into result digit[index].
  - If digit[index] > 9, store 4'b0000 instead (an invalid Excess-3 code) and set the error flag (sticky for the word).
  - index increments. When index = DIGITS-1 at the edge, go to DONE and set out_valid=1.
  - CONV lasts exactly DIGITS cycles.
- DONE:
  - out_valid=1. out_ex3 and out_err are stable and held until the handshake.
  - On out_valid & out_ready: out_valid=0, go to IDLE.
  - out_ex3 and out_err keep their value after the handshake until the next word is accepted.
- conv_bcd=0 in IDLE and DONE.
- Latency: out_valid rises on the DIGITS-th rising edge after the accepting edge. Throughput is one word per DIGITS+2 cycles when out_ready=1.
- Single-digit case: with DIGITS=1, CONV lasts one cycle.
- Backpressure: no new input is accepted while out_valid=1. A word is not accepted in the same cycle as the output handshake; in_ready rises the cycle after.
- in_bcd changing while state is not IDLE has no effect.
- Reset mid-conversion: the partial result is discarded and all outputs return to reset values immediately (asynchronous). No output handshake occurs for the aborted word.
- out_err=1 does not shorten the sequence; all digits are still processed.

Test Plan:
- DIGITS=4. Reset, then in_bcd=16'h1234 with in_valid=1 and out_ready=1 -> conv_bcd sequence 4,3,2,1 on consecutive cycles; out_valid rises 4 edges after accept; out_ex3=16'h4567, out_err=0.
- in_bcd=16'h0909 -> out_ex3=16'h3C3C, out_err=0.
- in_bcd=16'h12A4 -> out_ex3=16'h4507, out_err=1, still 4 conversion cycles.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_valid, out_ex3 and out_err stable, in_ready=0 throughout; out_ready=1 -> out_valid falls next edge, in_ready=1 the cycle after.
- Reset mid-operation: assert rst_n=0 while index=2 -> outputs return to reset values without waiting for a clock. After release, a new word 16'h9999 -> out_ex3=16'hCCCC.
- Back-to-back: two words 16'h0000 and 16'h5678 offered continuously with out_ready=1 -> results 16'h3333 then 16'h89AB; second accept occurs exactly DIGITS+2 cycles after the first.

Source files
------------

// File: rtl/bcd_ex3_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : bcd_ex3_seq_ctrl_if
// Brief    : Handshake and converter bus for the BCD-to-Excess-3 sequencer
// Revision : 1.0 - initial release
// ============================================================================
interface bcd_ex3_seq_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   in_bcd;
    logic [3:0]            conv_bcd;
    logic [3:0]            conv_ex3;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   out_ex3;
    logic                  out_err;
    logic                  busy;

    // slave is the sequencer; master is the producer/consumer/converter side
    modport slave (
        input  in_valid, in_bcd, conv_ex3, out_ready,
        output in_ready, conv_bcd, out_valid, out_ex3, out_err, busy
    );
    modport master (
        output in_valid, in_bcd, conv_ex3, out_ready,
        input  in_ready, conv_bcd, out_valid, out_ex3, out_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/bcd_ex3_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bcd_ex3_seq_ctrl
// Brief    : Converts a packed BCD word to Excess-3 one digit per clock using
//            a shared external 4-bit converter; flags digits above 9.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_ex3_seq_ctrl #(
    parameter int DIGITS = 4
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    bcd_ex3_seq_ctrl_if.slave  bus
);
    localparam int c_WIDTH = 4 * DIGITS;
    localparam int c_IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CONV = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_WIDTH-1:0]   r_in;
    logic [c_WIDTH-1:0]   r_res;
    logic                 r_err;
    logic [c_IDX_W-1:0]   r_idx;

    logic [3:0]           w_digit;
    logic [3:0]           w_ex3;
    logic                 w_bad;
    logic                 w_last;
    logic                 w_accept;
    logic                 w_release;

    always_comb begin
        w_digit = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == c_IDX_W'(i)) begin
                w_digit = r_in[4*i +: 4];
            end
        end
    end

    // Invalid digits are stored as 0000, which is not a legal Excess-3 code
    assign w_bad     = (w_digit > 4'd9);
    assign w_ex3     = w_bad ? 4'b0000 : bus.conv_ex3;
    assign w_last    = (r_idx == c_IDX_W'(DIGITS - 1));
    assign w_accept  = (r_state == S_IDLE) && bus.in_valid;
    assign w_release = (r_state == S_DONE) && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_CONV;
                end
            end
            S_CONV: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (w_release) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in  <= '0;
            r_res <= '0;
            r_err <= 1'b0;
            r_idx <= '0;
        end else if (w_accept) begin
            r_in  <= bus.in_bcd;
            r_res <= '0;
            r_err <= 1'b0;
            r_idx <= '0;
        end else if (r_state == S_CONV) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (r_idx == c_IDX_W'(i)) begin
                    r_res[4*i +: 4] <= w_ex3;
                end
            end
            r_err <= r_err | w_bad;
            r_idx <= w_last ? '0 : r_idx + 1'b1;
        end
    end

    // Result and error persist after the handshake until the next accept
    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.conv_bcd  = (r_state == S_CONV) ? w_digit : 4'd0;
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.out_ex3   = r_res;
    assign bus.out_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bcd_ex3_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_ex3_seq_ctrl
// Brief    : Self-checking bench: vector table, scoreboard, corner sequences
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_ex3_seq_ctrl;
    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bcd_ex3_seq_ctrl_if #(.DIGITS(DIGITS)) bus ();

    // External converter: plain add-3, no validity handling of its own
    assign bus.conv_ex3 = bus.conv_bcd + 4'd3;

    bcd_ex3_seq_ctrl #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [W-1:0] ex3;
        logic         err;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [W-1:0] bcd;
        logic [W-1:0] ex3;
        logic         err;
        int           hold;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_out_ex3"},   32'(bus.out_ex3),   32'd0);
        chk({tag, "_out_err"},   32'(bus.out_err),   32'd0);
        chk({tag, "_conv_bcd"},  32'(bus.conv_bcd),  32'd0);
        chk({tag, "_busy"},      32'(bus.busy),      32'd0);
    endtask

    // Called at a negedge; returns at the negedge after the output handshake
    task automatic send(input logic [W-1:0] bcd, input logic [W-1:0] ex3,
                        input logic err, input int hold, output int acc);
        int   t;
        exp_t e;
        bus.in_valid  = 1'b1;
        bus.in_bcd    = bcd;
        bus.out_ready = (hold == 0);
        t = 0;
        while (!bus.in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready got 0 expected 1");
        end
        e.ex3 = ex3;
        e.err = err;
        sb.push_back(e);
        @(posedge clk);
        #1;
        acc          = cyc;
        bus.in_valid = 1'b0;
        bus.in_bcd   = W'($urandom);
        for (int i = 0; i < DIGITS; i++) begin
            @(negedge clk);
            chk("conv_bcd_seq", 32'(bus.conv_bcd), 32'(bcd[4*i +: 4]));
            chk("busy_conv",    32'(bus.busy),     32'd1);
            chk("in_ready_conv", 32'(bus.in_ready), 32'd0);
            chk("out_valid_early", 32'(bus.out_valid), 32'd0);
        end
        @(negedge clk);
        chk("out_valid_rise", 32'(bus.out_valid), 32'd1);
        if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL sb_underflow: got 0 entries expected 1");
        end else begin
            e = sb.pop_front();
        end
        chk("out_ex3", 32'(bus.out_ex3), 32'(e.ex3));
        chk("out_err", 32'(bus.out_err), 32'(e.err));
        for (int h = 0; h < hold; h++) begin
            bus.in_valid = 1'b1;
            bus.in_bcd   = W'($urandom);
            @(negedge clk);
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_out_ex3",   32'(bus.out_ex3),   32'(e.ex3));
            chk("bp_out_err",   32'(bus.out_err),   32'(e.err));
            chk("bp_in_ready",  32'(bus.in_ready),  32'd0);
            chk("bp_conv_bcd",  32'(bus.conv_bcd),  32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("post_out_valid", 32'(bus.out_valid), 32'd0);
        chk("post_in_ready",  32'(bus.in_ready),  32'd1);
        chk("post_ex3_held",  32'(bus.out_ex3),   32'(e.ex3));
        chk("post_err_held",  32'(bus.out_err),   32'(e.err));
        chk("post_busy",      32'(bus.busy),      32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        int   a0, a1;
        vecs[0] = '{bcd: 16'h1234, ex3: 16'h4567, err: 1'b0, hold: 0};
        vecs[1] = '{bcd: 16'h0909, ex3: 16'h3C3C, err: 1'b0, hold: 0};
        vecs[2] = '{bcd: 16'h12A4, ex3: 16'h4507, err: 1'b1, hold: 5};
        vecs[3] = '{bcd: 16'hFFFF, ex3: 16'h0000, err: 1'b1, hold: 0};
        vecs[4] = '{bcd: 16'h9870, ex3: 16'hCBA3, err: 1'b0, hold: 2};

        bus.in_valid  = 1'b0;
        bus.in_bcd    = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            send(vecs[k].bcd, vecs[k].ex3, vecs[k].err, vecs[k].hold, a0);
        end

        send(16'h0000, 16'h3333, 1'b0, 0, a0);
        send(16'h5678, 16'h89AB, 1'b0, 0, a1);
        chk("b2b_accept_gap", 32'(a1 - a0), 32'(DIGITS + 2));

        // Abort a word mid-conversion with an asynchronous reset
        bus.in_valid  = 1'b1;
        bus.in_bcd    = 16'h5678;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_conv_idx2", 32'(bus.conv_bcd), 32'h6);
        #1 rst_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        send(16'h9999, 16'hCCCC, 1'b0, 0, a0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
